fwgpio_irq: RTL and testbench
=============================

# fwgpio_irq

Parametrised successor GPIO block: N_PINS pads, each muxed either to a register-controlled GPIO or to one of N_BANKS peripheral banks, with input synchronisation, word-wide and atomic set/clear output access, and per-pin edge/level interrupts merged onto one `irq` line. It sits between the pad ring and peripheral banks as a target on the `rt_` addr/line-enable register bus.

## Interface
- N_PINS, 32: pin count, 1..32.
- N_BANKS, 2: peripheral bank count, 1..16.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- ADR_W, 7: word-address width; 2^(ADR_W-1) >= N_PINS.
- clock  in  1  sole clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- rt_adr  in  ADR_W  word address.
- rt_dat_w  in  32  write data.
- rt_dat_r  out  32  read data; valid while rt_ready=1.
- rt_valid  in  1  request; held until rt_ready.
- rt_we  in  1  1=write, 0=read.
- rt_ready  out  1  one-cycle completion pulse.
- banks_o  in  N_BANKS*N_PINS  bank output values; bit index N_PINS*b+p.
- banks_oe  in  N_BANKS*N_PINS  bank output enables.
- banks_i  out  N_BANKS*N_PINS  pad input routed back to the owning bank.
- pin_o  out  N_PINS  pad output value.
- pin_oe  out  N_PINS  pad output enable.
- pin_i  in  N_PINS  pad input, asynchronous.
- irq  out  1  level interrupt = |(IRQ_STAT & IRQ_EN).

## Operation
- Address decode: rt_adr[ADR_W-1]=1 selects per-pin CTRL[p], p=rt_adr[ADR_W-2:0]; p>=N_PINS reads 0, writes ignored. rt_adr[ADR_W-1]=0 selects a global register by rt_adr[2:0]; rt_adr[ADR_W-2:3]!=0 reads 0.
- CTRL[p] bit fields: [3:0] banksel; [8] bank_en; [9] out; [10] oe; [12:11] irq_mode (00 rising, 01 falling, 10 both, 11 high-level); [13] irq_en. Other bits read 0.
- Global registers: 0 OUT (RW, aliases CTRL.out); 1 OE (RW, aliases CTRL.oe); 2 IN (RO, synchronised pins); 3 IRQ_EN (RW, aliases CTRL.irq_en); 4 IRQ_STAT (RO, write-1-to-clear); 5 OUT_SET (WO, 1 bits set OUT); 6 OUT_CLR (WO, 1 bits clear OUT); 7 PARAM (RO: [7:0]=N_PINS, [15:8]=N_BANKS, [19:16]=SYNC_STAGES). WO registers read 0. Bits >= N_PINS read 0.
- Pad mux: bank_en=0 drives pin_o=out and pin_oe=oe. bank_en=1 with banksel<N_BANKS drives banks_o/banks_oe[N_PINS*banksel+p]. bank_en=1 with banksel>=N_BANKS drives pin_o=0 and pin_oe=0.
- banks_i[N_PINS*b+p] = raw pin_i[p] when bank_en=1 and banksel==b; otherwise 0.
- Input path: a SYNC_STAGES-deep flop chain produces sync[p]; prev[p] holds sync[p] delayed by one cycle.
- Interrupt events: rising = sync & ~prev; falling = ~sync & prev; level = sync. IRQ_STAT[p] sets on an event only when irq_en[p]=1. Disabling irq_en leaves the status bit set.
- Simultaneous W1C and new event on the same bit: the set wins. Level mode re-sets the bit the cycle after a clear while the pin remains high.
- Register-file write priority within one cycle: only one bus write completes per access, so there are no write-write conflicts. OUT_SET and OUT_CLR act on the current OUT value.

## Timing
- Reset (reset=0, asynchronous) clears all CTRL fields, sync, prev, IRQ_STAT and the access state. Outputs held at reset: rt_ready=0, rt_dat_r=0, pin_o=0, pin_oe=0, banks_i=0, irq=0.
- Access FSM has two states:
  - IDLE: rt_valid=1 → BUSY. A write commits on this edge; a read captures data on this edge.
  - BUSY: rt_ready=1 for exactly one cycle → IDLE. rt_dat_r carries the read data (0 for writes).
- Every access completes in 2 cycles, so back-to-back throughput is one access per 2 cycles. A read issued immediately after a write returns the written value.
- rt_dat_r holds its value until the next accepted access.
- Pad mux and banks_i are combinational. A CTRL write reaches pin_o/pin_oe on the cycle after the write edge.
- pin_i transition → IN register updates SYNC_STAGES edges later → IRQ_STAT and irq assert at edge SYNC_STAGES+1.
- After a W1C write edge, irq deasserts the following cycle unless re-set.
- Asserting reset mid-access aborts the access: rt_ready stays 0 and no pending write is committed.

## Test plan
- Reset defaults: hold reset low, then read all globals → 0 except PARAM=0x0002_0220. pin_oe=0, irq=0.
- GPIO drive: write OUT=0xA5, then OE=0xFF → pin_o[7:0]=0xA5, pin_oe[7:0]=0xFF. Then OUT_SET=0x02 and OUT_CLR=0x80 → OUT reads 0x27.
- Bank mux: write CTRL[3]=0x101 (bank_en=1, banksel=1). Drive banks_o[35]=1 and pin_i[3]=1 → pin_o[3]=1, banks_i[35]=1, banks_i[3]=0. Then banksel=5 → pin_o[3]=0, pin_oe[3]=0.
- Rising-edge irq: CTRL[0]=0x2000, then pulse pin_i[0] 0→1 → irq at edge 3. W1C IRQ_STAT=0x1 → irq=0 next cycle.
- Level irq with race: set CTRL[1] to irq_mode=11 with irq_en=1, hold pin_i[1]=1, W1C bit 1 → IRQ_STAT[1] reads 1 again. A falling edge on pin 1 in mode 01 coinciding with the W1C leaves the bit set.
- Reset mid-access: assert reset during the BUSY cycle of a write to OUT → rt_ready=0, OUT=0 after release.

Source files
------------

// File: rtl/fwgpio_irq_if.sv
// Register-bus bundle for fwgpio_irq: word address, line-wide data, valid/ready handshake.
// The master holds rt_valid until it sees the one-cycle rt_ready pulse.
interface fwgpio_irq_if #(
    parameter int ADR_W = 7
);
    logic [ADR_W-1:0] rt_adr;
    logic [31:0]      rt_dat_w;
    logic [31:0]      rt_dat_r;
    logic             rt_valid;
    logic             rt_we;
    logic             rt_ready;

    modport master (
        output rt_adr, rt_dat_w, rt_valid, rt_we,
        input  rt_dat_r, rt_ready
    );

    modport slave (
        input  rt_adr, rt_dat_w, rt_valid, rt_we,
        output rt_dat_r, rt_ready
    );
endinterface

// File: rtl/fwgpio_irq.sv
// GPIO block with per-pin peripheral-bank muxing, synchronised inputs, word-wide and set/clear
// output access, and per-pin edge/level interrupts merged onto one irq line.
module fwgpio_irq #(
    parameter int N_PINS      = 32,
    parameter int N_BANKS     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ADR_W       = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    fwgpio_irq_if.slave               rt,
    input  logic [N_BANKS*N_PINS-1:0] banks_o,
    input  logic [N_BANKS*N_PINS-1:0] banks_oe,
    output logic [N_BANKS*N_PINS-1:0] banks_i,
    output logic [N_PINS-1:0]         pin_o,
    output logic [N_PINS-1:0]         pin_oe,
    input  logic [N_PINS-1:0]         pin_i,
    output logic                      irq
);

    localparam int PW = ADR_W - 1;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    typedef enum logic [2:0] {
        R_OUT      = 3'd0,
        R_OE       = 3'd1,
        R_IN       = 3'd2,
        R_IRQ_EN   = 3'd3,
        R_IRQ_STAT = 3'd4,
        R_OUT_SET  = 3'd5,
        R_OUT_CLR  = 3'd6,
        R_PARAM    = 3'd7
    } reg_e;

    state_e                          state_q, state_d;
    logic [31:0]                     dat_r_q, dat_r_d;
    logic [N_PINS-1:0][3:0]          banksel_q, banksel_d;
    logic [N_PINS-1:0][1:0]          irq_mode_q, irq_mode_d;
    logic [N_PINS-1:0]               bank_en_q, bank_en_d;
    logic [N_PINS-1:0]               out_q, out_d;
    logic [N_PINS-1:0]               oe_q, oe_d;
    logic [N_PINS-1:0]               irq_en_q, irq_en_d;
    logic [N_PINS-1:0]               stat_q, stat_d;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;
    logic [N_PINS-1:0]               prev_q;

    logic [N_PINS-1:0] sync;
    logic [N_PINS-1:0] evt;
    logic [N_PINS-1:0] stat_clr;
    logic [31:0]       rd_word;
    logic              accept;
    logic              sel_pin;
    logic              glb_ok;
    logic [PW-1:0]     pin_adr;
    logic [2:0]        glb_idx;

    assign sel_pin = rt.rt_adr[ADR_W-1];
    assign pin_adr = rt.rt_adr[PW-1:0];
    assign glb_idx = pin_adr[2:0];
    assign glb_ok  = !sel_pin && (pin_adr[PW-1:3] == '0);
    assign accept  = (state_q == S_IDLE) && rt.rt_valid;
    assign sync    = sync_q[SYNC_STAGES-1];

    // Access FSM: accept (commit write / capture read) in IDLE, pulse ready in BUSY.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path leaves a latch.
        state_d = state_q;
        dat_r_d = dat_r_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_BUSY;
                dat_r_d = rt.rt_we ? 32'd0 : rd_word;
            end
            S_BUSY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rt.rt_ready = (state_q == S_BUSY);
    assign rt.rt_dat_r = dat_r_q;

    always_comb begin
        rd_word = '0;
        if (sel_pin) begin
            for (int p = 0; p < N_PINS; p++) begin
                if (pin_adr == PW'(p)) begin
                    rd_word[3:0]   = banksel_q[p];
                    rd_word[8]     = bank_en_q[p];
                    rd_word[9]     = out_q[p];
                    rd_word[10]    = oe_q[p];
                    rd_word[12:11] = irq_mode_q[p];
                    rd_word[13]    = irq_en_q[p];
                end
            end
        end else if (glb_ok) begin
            case (glb_idx)
                R_OUT:      rd_word[N_PINS-1:0] = out_q;
                R_OE:       rd_word[N_PINS-1:0] = oe_q;
                R_IN:       rd_word[N_PINS-1:0] = sync;
                R_IRQ_EN:   rd_word[N_PINS-1:0] = irq_en_q;
                R_IRQ_STAT: rd_word[N_PINS-1:0] = stat_q;
                R_PARAM: begin
                    rd_word[7:0]   = 8'(N_PINS);
                    rd_word[15:8]  = 8'(N_BANKS);
                    rd_word[19:16] = 4'(SYNC_STAGES);
                end
                default:    rd_word = '0;
            endcase
        end
    end

    // Register-file writes; OUT, OE and IRQ_EN are word views of the per-pin CTRL bits.
    always_comb begin
        banksel_d  = banksel_q;
        irq_mode_d = irq_mode_q;
        bank_en_d  = bank_en_q;
        out_d      = out_q;
        oe_d       = oe_q;
        irq_en_d   = irq_en_q;
        stat_clr   = '0;
        if (accept && rt.rt_we) begin
            if (sel_pin) begin
                for (int p = 0; p < N_PINS; p++) begin
                    if (pin_adr == PW'(p)) begin
                        banksel_d[p]  = rt.rt_dat_w[3:0];
                        bank_en_d[p]  = rt.rt_dat_w[8];
                        out_d[p]      = rt.rt_dat_w[9];
                        oe_d[p]       = rt.rt_dat_w[10];
                        irq_mode_d[p] = rt.rt_dat_w[12:11];
                        irq_en_d[p]   = rt.rt_dat_w[13];
                    end
                end
            end else if (glb_ok) begin
                case (glb_idx)
                    R_OUT:      out_d    = rt.rt_dat_w[N_PINS-1:0];
                    R_OE:       oe_d     = rt.rt_dat_w[N_PINS-1:0];
                    R_IRQ_EN:   irq_en_d = rt.rt_dat_w[N_PINS-1:0];
                    R_IRQ_STAT: stat_clr = rt.rt_dat_w[N_PINS-1:0];
                    R_OUT_SET:  out_d    = out_q | rt.rt_dat_w[N_PINS-1:0];
                    R_OUT_CLR:  out_d    = out_q & ~rt.rt_dat_w[N_PINS-1:0];
                    default:    stat_clr = '0;
                endcase
            end
        end
    end

    // Interrupt status: a new event in the same cycle as a W1C wins over the clear.
    always_comb begin
        evt = '0;
        for (int p = 0; p < N_PINS; p++) begin
            case (irq_mode_q[p])
                2'b00:   evt[p] = sync[p] & ~prev_q[p];
                2'b01:   evt[p] = ~sync[p] & prev_q[p];
                2'b10:   evt[p] = sync[p] ^ prev_q[p];
                default: evt[p] = sync[p];
            endcase
        end
        stat_d = (stat_q & ~stat_clr) | (evt & irq_en_q);
    end

    assign irq = |(stat_q & irq_en_q);

    // Pad mux and bank input routing; an out-of-range banksel parks the pad as an undriven input.
    always_comb begin
        pin_o   = '0;
        pin_oe  = '0;
        banks_i = '0;
        for (int p = 0; p < N_PINS; p++) begin
            if (!bank_en_q[p]) begin
                pin_o[p]  = out_q[p];
                pin_oe[p] = oe_q[p];
            end else begin
                for (int b = 0; b < N_BANKS; b++) begin
                    if (banksel_q[p] == 4'(b)) begin
                        pin_o[p]              = banks_o[N_PINS*b+p];
                        pin_oe[p]             = banks_oe[N_PINS*b+p];
                        banks_i[N_PINS*b+p]   = pin_i[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dat_r_q    <= '0;
            banksel_q  <= '0;
            irq_mode_q <= '0;
            bank_en_q  <= '0;
            out_q      <= '0;
            oe_q       <= '0;
            irq_en_q   <= '0;
            stat_q     <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            dat_r_q    <= dat_r_d;
            banksel_q  <= banksel_d;
            irq_mode_q <= irq_mode_d;
            bank_en_q  <= bank_en_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            irq_en_q   <= irq_en_d;
            stat_q     <= stat_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q     <= sync;
        end
    end

endmodule

// File: tb/tb_fwgpio_irq.sv
// Self-checking bench for fwgpio_irq: register-map vector table plus hand-written pad, interrupt
// and reset sequences; read data is scored against a queue filled when each access is issued.
module tb_fwgpio_irq;

    localparam int N_PINS  = 32;
    localparam int N_BANKS = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [N_BANKS*N_PINS-1:0] banks_o  = '0;
    logic [N_BANKS*N_PINS-1:0] banks_oe = '0;
    logic [N_BANKS*N_PINS-1:0] banks_i;
    logic [N_PINS-1:0]         pin_o;
    logic [N_PINS-1:0]         pin_oe;
    logic [N_PINS-1:0]         pin_i = '0;
    logic                      irq;

    fwgpio_irq_if #(.ADR_W(7)) rt ();

    fwgpio_irq #(
        .N_PINS(N_PINS), .N_BANKS(N_BANKS), .SYNC_STAGES(2), .ADR_W(7)
    ) dut (
        .clock(clock), .reset(reset), .rt(rt),
        .banks_o(banks_o), .banks_oe(banks_oe), .banks_i(banks_i),
        .pin_o(pin_o), .pin_oe(pin_oe), .pin_i(pin_i), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        bit          we;
        logic [6:0]  adr;
        logic [31:0] wdat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: each completed access pops the value queued when it was issued.
    always @(negedge clock) begin
        if (reset && rt.rt_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'(rt.rt_ready), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, rt.rt_dat_r, e.val);
            end
        end
    end

    task automatic access(input bit we, input logic [6:0] adr, input logic [31:0] wd,
                          input logic [31:0] exp, input string name);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        rt.rt_valid  = 1'b1;
        rt.rt_we     = we;
        rt.rt_adr    = adr;
        rt.rt_dat_w  = wd;
        exp_q.push_back('{exp, name});
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clock);
            #1;
            seen = rt.rt_ready;
        end
        rt.rt_valid = 1'b0;
        rt.rt_we    = 1'b0;
        if (!seen) begin
            check({name, "_timeout"}, 32'(rt.rt_ready), 32'd1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic wr(input logic [6:0] adr, input logic [31:0] wd);
        access(1'b1, adr, wd, 32'd0, $sformatf("wr_%02h", adr));
    endtask

    task automatic rd(input logic [6:0] adr, input logic [31:0] exp, input string name);
        access(1'b0, adr, 32'd0, exp, name);
    endtask

    initial begin
        rt.rt_valid = 1'b0;
        rt.rt_we    = 1'b0;
        rt.rt_adr   = '0;
        rt.rt_dat_w = '0;

        // Reset state held low
        repeat (3) @(negedge clock);
        check("rst_ready",  32'(rt.rt_ready), 32'd0);
        check("rst_dat_r",  rt.rt_dat_r, 32'd0);
        check("rst_pin_oe", pin_oe, 32'd0);
        check("rst_pin_o",  pin_o, 32'd0);
        check("rst_irq",    32'(irq), 32'd0);
        reset = 1'b1;

        // Register map defaults and decode corners
        vecs.push_back('{1'b0, 7'h00, 32'h0, 32'h0000_0000, "def_out"});
        vecs.push_back('{1'b0, 7'h01, 32'h0, 32'h0000_0000, "def_oe"});
        vecs.push_back('{1'b0, 7'h02, 32'h0, 32'h0000_0000, "def_in"});
        vecs.push_back('{1'b0, 7'h03, 32'h0, 32'h0000_0000, "def_irq_en"});
        vecs.push_back('{1'b0, 7'h04, 32'h0, 32'h0000_0000, "def_irq_stat"});
        vecs.push_back('{1'b0, 7'h05, 32'h0, 32'h0000_0000, "def_out_set"});
        vecs.push_back('{1'b0, 7'h06, 32'h0, 32'h0000_0000, "def_out_clr"});
        vecs.push_back('{1'b0, 7'h07, 32'h0, 32'h0002_0220, "def_param"});
        vecs.push_back('{1'b0, 7'h40, 32'h0, 32'h0000_0000, "def_ctrl0"});
        vecs.push_back('{1'b0, 7'h0F, 32'h0, 32'h0000_0000, "hi_global_rd"});
        vecs.push_back('{1'b1, 7'h60, 32'hFFFF_FFFF, 32'h0, "wr_ctrl32"});
        vecs.push_back('{1'b0, 7'h60, 32'h0, 32'h0000_0000, "rd_ctrl32"});
        vecs.push_back('{1'b1, 7'h07, 32'hFFFF_FFFF, 32'h0, "wr_param"});
        vecs.push_back('{1'b0, 7'h07, 32'h0, 32'h0002_0220, "rd_param_ro"});
        vecs.push_back('{1'b1, 7'h02, 32'hFFFF_FFFF, 32'h0, "wr_in"});
        vecs.push_back('{1'b0, 7'h02, 32'h0, 32'h0000_0000, "rd_in_ro"});
        vecs.push_back('{1'b1, 7'h5F, 32'h0000_3FFF, 32'h0, "wr_ctrl31"});
        vecs.push_back('{1'b0, 7'h5F, 32'h0, 32'h0000_3F0F, "rd_ctrl31"});
        vecs.push_back('{1'b1, 7'h5F, 32'h0000_0000, 32'h0, "clr_ctrl31"});
        for (int i = 0; i < vecs.size(); i++)
            access(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].exp, vecs[i].name);

        // GPIO drive and atomic set/clear
        wr(7'h00, 32'h0000_00A5);
        wr(7'h01, 32'h0000_00FF);
        check("gpio_pin_o",  pin_o,  32'h0000_00A5);
        check("gpio_pin_oe", pin_oe, 32'h0000_00FF);
        wr(7'h05, 32'h0000_0002);
        wr(7'h06, 32'h0000_0080);
        rd(7'h00, 32'h0000_0027, "out_after_set_clr");
        rd(7'h01, 32'h0000_00FF, "oe_readback");
        rd(7'h40, 32'h0000_0600, "ctrl0_alias");
        rd(7'h47, 32'h0000_0400, "ctrl7_alias");
        check("gpio_pin_o2", pin_o, 32'h0000_0027);

        // Bank mux on pin 3
        wr(7'h43, 32'h0000_0101);
        banks_o[35]  = 1'b1;
        banks_oe[35] = 1'b1;
        pin_i[3]     = 1'b1;
        #1;
        check("bank_pin_o3",   32'(pin_o[3]),   32'd1);
        check("bank_pin_oe3",  32'(pin_oe[3]),  32'd1);
        check("bank_i35",      32'(banks_i[35]), 32'd1);
        check("bank_i3",       32'(banks_i[3]),  32'd0);
        wr(7'h43, 32'h0000_0105);
        check("badsel_pin_o3",  32'(pin_o[3]),  32'd0);
        check("badsel_pin_oe3", 32'(pin_oe[3]), 32'd0);
        check("badsel_i35",     32'(banks_i[35]), 32'd0);
        rd(7'h43, 32'h0000_0105, "ctrl3_readback");
        rd(7'h01, 32'h0000_00F7, "oe_after_ctrl3");
        pin_i[3]     = 1'b0;
        banks_o[35]  = 1'b0;
        banks_oe[35] = 1'b0;

        // Rising-edge interrupt latency and W1C
        wr(7'h40, 32'h0000_2000);
        @(negedge clock);
        pin_i[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rise_irq_edge2", 32'(irq), 32'd0);
        @(posedge clock); #1;
        check("rise_irq_edge3", 32'(irq), 32'd1);
        rd(7'h02, 32'h0000_0001, "in_after_rise");
        rd(7'h04, 32'h0000_0001, "stat_after_rise");
        wr(7'h04, 32'h0000_0001);
        check("irq_after_w1c", 32'(irq), 32'd0);
        rd(7'h04, 32'h0000_0000, "stat_after_w1c");

        // Level mode re-sets after a clear while the pin stays high
        pin_i[1] = 1'b1;
        wr(7'h41, 32'h0000_3800);
        repeat (4) @(negedge clock);
        rd(7'h04, 32'h0000_0002, "level_set");
        wr(7'h04, 32'h0000_0002);
        rd(7'h04, 32'h0000_0002, "level_reset");
        check("level_irq", 32'(irq), 32'd1);

        // Falling-edge event landing on the same edge as its W1C
        pin_i[2] = 1'b1;
        wr(7'h42, 32'h0000_2800);
        repeat (4) @(negedge clock);
        rd(7'h04, 32'h0000_0002, "fall_none_yet");
        @(negedge clock);
        pin_i[2] = 1'b0;
        @(negedge clock);
        wr(7'h04, 32'h0000_0004);
        rd(7'h04, 32'h0000_0006, "fall_race_set_wins");
        rd(7'h03, 32'h0000_0007, "irq_en_alias");
        wr(7'h41, 32'h0000_1800);
        rd(7'h04, 32'h0000_0006, "stat_kept_when_disabled");
        rd(7'h03, 32'h0000_0005, "irq_en_after_disable");
        wr(7'h04, 32'h0000_0007);
        rd(7'h04, 32'h0000_0000, "stat_all_cleared");
        check("irq_all_cleared", 32'(irq), 32'd0);

        // Reset asserted during the BUSY cycle of a write
        @(negedge clock);
        rt.rt_valid = 1'b1;
        rt.rt_we    = 1'b1;
        rt.rt_adr   = 7'h00;
        rt.rt_dat_w = 32'h0000_00FF;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(rt.rt_ready), 32'd0);
        check("abort_pin_o", pin_o, 32'd0);
        check("abort_irq",   32'(irq), 32'd0);
        rt.rt_valid = 1'b0;
        rt.rt_we    = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        rd(7'h00, 32'h0000_0000, "out_after_abort");
        rd(7'h03, 32'h0000_0000, "irq_en_after_abort");

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
